// File: rtl/iobuf_pkg.sv
// iobuf_pkg: shared types and helpers for the iobuf_bank I/O channel bank.
//   iobuf_state_e  - reconfiguration sequencer states
//   DIR_IN/DIR_OUT - per-channel direction encodings used by cfg_dir
//   settle_cnt_w() - width of the settle down-counter for a given settle time
package iobuf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        TURN   = 2'd2,
        SETTLE = 2'd3
    } iobuf_state_e;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    function automatic int settle_cnt_w(input int settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/iobuf_sync.sv
// iobuf_sync: one-bit two-flop synchroniser for an asynchronous pin input.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles behind d
module iobuf_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/iobuf_bank.sv
// iobuf_bank: bank of CHANNELS Bus Pirate I/O channels. Each channel drives one
// FPGA tristate pin (pin_oe/pin_dout/pin_din) and one external level-shift
// buffer (buf_dir/buf_od). Direction and open-drain mode are reconfigured at
// runtime through a cfg_valid/cfg_ready handshake; every change is sequenced
// break-before-make: pin disabled, buffer turned, settle wait, pin re-enabled.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   cfg_valid/cfg_ready   - configuration handshake (ready only when idle)
//   cfg_dir, cfg_od       - requested direction (1=output) and open-drain select
//   busy                  - reconfiguration in progress (~cfg_ready)
//   dout                  - data to drive; reaches pin_oe/pin_dout one cycle later
//   din                   - pin_din after a two-flop synchroniser (all modes)
//   pin_oe, pin_dout      - to tristate pin OUTPUT_ENABLE / D_OUT_0
//   pin_din               - from tristate pin D_IN_0
//   buf_dir, buf_od       - external buffer direction (1=FPGA->bus) / open-drain
//
// Optional build macro IOBUF_CONTENTION_EN adds:
//   contention_clr (in)   - clears all contention flags and counters
//   contention (out)      - sticky per-channel flag: a push-pull output read back
//                           a different level for CONTENTION_LIMIT cycles in a row
module iobuf_bank
    import iobuf_pkg::*;
#(
    parameter int CHANNELS         = 8,
    parameter int SETTLE_CYCLES    = 4,
    parameter int CONTENTION_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHANNELS-1:0] cfg_dir,
    input  logic [CHANNELS-1:0] cfg_od,
    output logic                busy,
    input  logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] pin_oe,
    output logic [CHANNELS-1:0] pin_dout,
    input  logic [CHANNELS-1:0] pin_din,
    output logic [CHANNELS-1:0] buf_dir,
    output logic [CHANNELS-1:0] buf_od
`ifdef IOBUF_CONTENTION_EN
    ,
    input  logic                contention_clr,
    output logic [CHANNELS-1:0] contention
`endif
);

    localparam int CNT_W = settle_cnt_w(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    iobuf_state_e        state, state_nxt;
    logic [CNT_W-1:0]    settle_cnt;
    logic [CHANNELS-1:0] cur_dir, cur_od;
    logic [CHANNELS-1:0] pend_dir, pend_od;
    logic [CHANNELS-1:0] chg_mask;
    logic [CHANNELS-1:0] chg_req;
    logic [CHANNELS-1:0] oe_nxt, dout_nxt;
    logic                accept;
    logic                load_pend;
    logic                load_buf;
    logic                commit;

    assign chg_req = (cfg_dir ^ cur_dir) | (cfg_od ^ cur_od);

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next state and control strobes
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        accept    = 1'b0;
        load_pend = 1'b0;
        load_buf  = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                accept    = cfg_valid;
                // A request identical to the current setup completes the
                // handshake without touching any pin or buffer.
                if (accept && (chg_req != '0)) begin
                    load_pend = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = TURN;
            end
            TURN: begin
                load_buf  = 1'b1;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy = ~cfg_ready;
    end

    // Drive mapping; channels under reconfiguration stay tristated until the
    // new setup is committed, everything else keeps following dout.
    always_comb begin
        oe_nxt   = '0;
        dout_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chg_mask[i] || (cur_dir[i] == DIR_IN)) begin
                oe_nxt[i]   = 1'b0;
                dout_nxt[i] = 1'b0;
            end else if (cur_od[i]) begin
                // Open drain: only ever pull low, release for a 1.
                oe_nxt[i]   = ~dout[i];
                dout_nxt[i] = 1'b0;
            end else begin
                oe_nxt[i]   = 1'b1;
                dout_nxt[i] = dout[i];
            end
        end
    end

    // Configuration, buffer control and pin drive registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_dir    <= '0;
            cur_od     <= '0;
            pend_dir   <= '0;
            pend_od    <= '0;
            chg_mask   <= '0;
            settle_cnt <= '0;
            buf_dir    <= '0;
            buf_od     <= '0;
            pin_oe     <= '0;
            pin_dout   <= '0;
        end else begin
            if (load_pend) begin
                pend_dir <= cfg_dir;
                pend_od  <= cfg_od;
                chg_mask <= chg_req;
            end
            // pin_oe of every changed channel has been 0 since the DRAIN edge,
            // so the buffer can turn here without fighting the pin.
            if (load_buf) begin
                buf_dir    <= (buf_dir & ~chg_mask) | (pend_dir & chg_mask);
                buf_od     <= (buf_od & ~chg_mask) | (pend_od & chg_mask);
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (commit) begin
                cur_dir  <= pend_dir;
                cur_od   <= pend_od;
                chg_mask <= '0;
            end
            pin_oe   <= oe_nxt;
            pin_dout <= dout_nxt;
        end
    end

    // Pin input synchronisers
    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        iobuf_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (pin_din[g]),
            .q     (din[g])
        );
    end

`ifdef IOBUF_CONTENTION_EN
    localparam int CONT_W = $clog2(CONTENTION_LIMIT + 1);
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(CONTENTION_LIMIT);

    logic [CHANNELS-1:0] pdout_p1, pdout_p2;
    logic [CHANNELS-1:0] watch;
    logic [CONT_W-1:0]   cont_cnt [CHANNELS];

    // Only settled push-pull outputs have a well-defined expected readback.
    assign watch = cur_dir & ~cur_od & ~chg_mask;

    // pin_dout delayed to line up with the synchroniser latency of din
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pdout_p1   <= '0;
            pdout_p2   <= '0;
            contention <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cont_cnt[i] <= '0;
            end
        end else begin
            pdout_p1 <= pin_dout;
            pdout_p2 <= pdout_p1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (contention_clr) begin
                    cont_cnt[i]   <= '0;
                    contention[i] <= 1'b0;
                end else if (watch[i] && (din[i] != pdout_p2[i])) begin
                    if (cont_cnt[i] != CONT_MAX) begin
                        cont_cnt[i] <= cont_cnt[i] + CONT_W'(1);
                    end
                    if (cont_cnt[i] >= (CONT_MAX - CONT_W'(1))) begin
                        contention[i] <= 1'b1;
                    end
                end else begin
                    cont_cnt[i] <= '0;
                end
            end
        end
    end
`else
    // Contention monitor not built; the limit is accepted but has no effect.
    if (CONTENTION_LIMIT < 1) begin : g_contention_limit_unused
    end
`endif

endmodule
